// File: rtl/axi_lite_master.sv
// AXI-Lite initiator: turns one command (single read or write) into AW/W/B or AR/R
// handshakes and returns the slave's data and response code on a valid/ready port.
//
// state        | meaning
// IDLE         | cmd_ready high, waiting for a command
// WR_ADDR_DATA | driving AW and W; each drops once its own handshake completes
// WR_RESP      | bready high, waiting for B
// RD_ADDR      | arvalid high, waiting for arready
// RD_DATA      | rready high, waiting for R
// RESPOND      | rsp_valid high with rsp_* held until rsp_ready
module axi_lite_master #(
   parameter int AXI_LITE_ADDR_WIDTH = 8
) (
   input  logic                           m_axi_lite_aclk,
   input  logic                           axi_resetn,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic                           cmd_write,
   input  logic [AXI_LITE_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]                    cmd_wdata,
   input  logic [3:0]                     cmd_wstrb,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [31:0]                    rsp_rdata,
   output logic [1:0]                     rsp_resp,
   output logic                           rsp_write,
   output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_awaddr,
   output logic                           m_axi_lite_awvalid,
   input  logic                           m_axi_lite_awready,
   output logic [31:0]                    m_axi_lite_wdata,
   output logic [3:0]                     m_axi_lite_wstrb,
   output logic                           m_axi_lite_wvalid,
   input  logic                           m_axi_lite_wready,
   input  logic [1:0]                     m_axi_lite_bresp,
   input  logic                           m_axi_lite_bvalid,
   output logic                           m_axi_lite_bready,
   output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_araddr,
   output logic                           m_axi_lite_arvalid,
   input  logic                           m_axi_lite_arready,
   input  logic [31:0]                    m_axi_lite_rdata,
   input  logic [1:0]                     m_axi_lite_rresp,
   input  logic                           m_axi_lite_rvalid,
   output logic                           m_axi_lite_rready
);

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      RESPOND
   } state_t;

   state_t                         state_q, state_d;
   logic [AXI_LITE_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]                    wdata_q, wdata_d;
   logic [3:0]                     wstrb_q, wstrb_d;
   logic                           aw_done_q, aw_done_d;
   logic                           w_done_q, w_done_d;
   logic [31:0]                    rsp_rdata_q, rsp_rdata_d;
   logic [1:0]                     rsp_resp_q, rsp_resp_d;
   logic                           rsp_write_q, rsp_write_d;

   always_ff @(posedge m_axi_lite_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         rsp_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         rsp_write_q <= rsp_write_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      rsp_write_d = rsp_write_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d    = cmd_addr;
               wdata_d   = cmd_wdata;
               wstrb_d   = cmd_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = cmd_write ? WR_ADDR_DATA : RD_ADDR;
            end
         end
         WR_ADDR_DATA: begin
            // AW and W finish independently, in either order or together
            if (m_axi_lite_awvalid && m_axi_lite_awready) aw_done_d = 1'b1;
            if (m_axi_lite_wvalid && m_axi_lite_wready)   w_done_d  = 1'b1;
            if (aw_done_d && w_done_d) state_d = WR_RESP;
         end
         WR_RESP: begin
            if (m_axi_lite_bvalid) begin
               rsp_resp_d  = m_axi_lite_bresp;
               rsp_rdata_d = '0;
               rsp_write_d = 1'b1;
               state_d     = RESPOND;
            end
         end
         RD_ADDR: begin
            if (m_axi_lite_arready) state_d = RD_DATA;
         end
         RD_DATA: begin
            if (m_axi_lite_rvalid) begin
               rsp_resp_d  = m_axi_lite_rresp;
               rsp_rdata_d = m_axi_lite_rdata;
               rsp_write_d = 1'b0;
               state_d     = RESPOND;
            end
         end
         RESPOND: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // every handshake output decodes registered state only, so reset clears them at once
   assign cmd_ready          = (state_q == IDLE);
   assign m_axi_lite_awvalid = (state_q == WR_ADDR_DATA) && !aw_done_q;
   assign m_axi_lite_wvalid  = (state_q == WR_ADDR_DATA) && !w_done_q;
   assign m_axi_lite_bready  = (state_q == WR_RESP);
   assign m_axi_lite_arvalid = (state_q == RD_ADDR);
   assign m_axi_lite_rready  = (state_q == RD_DATA);
   assign rsp_valid          = (state_q == RESPOND);

   assign m_axi_lite_awaddr  = addr_q;
   assign m_axi_lite_araddr  = addr_q;
   assign m_axi_lite_wdata   = wdata_q;
   assign m_axi_lite_wstrb   = wstrb_q;
   assign rsp_rdata          = rsp_rdata_q;
   assign rsp_resp           = rsp_resp_q;
   assign rsp_write          = rsp_write_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: directed commands against a small AXI-Lite slave model with
// programmable ready/valid delays; responses are checked by a scoreboard monitor.
module tb_axi_lite_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [7:0]  awaddr, araddr;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int total = 0;
   int bad = 0;
   int rsp_cnt = 0;
   int b_cnt = 0;
   logic [34:0] sb [$];

   always #5 clk = ~clk;

   axi_lite_master #(.AXI_LITE_ADDR_WIDTH(8)) dut (
      .m_axi_lite_aclk(clk), .axi_resetn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_write(rsp_write),
      .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
      .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb), .m_axi_lite_wvalid(wvalid),
      .m_axi_lite_wready(wready),
      .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready),
      .m_axi_lite_araddr(araddr), .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
      .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp), .m_axi_lite_rvalid(rvalid),
      .m_axi_lite_rready(rready)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // slave model: four 32-bit registers at byte addresses 0x0/0x4/0x8/0xC
   int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   int          aw_cnt, w_cnt, ar_cnt, r_cnt;
   logic        have_aw, have_w, r_pend;
   logic [7:0]  aw_addr_s;
   logic [31:0] w_data_s, rdata_s;
   logic [3:0]  w_strb_s;
   logic [31:0] mem [4];
   logic        aw_hs, w_hs;
   logic [1:0]  wr_idx;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;

   assign awready = awvalid && (aw_cnt >= aw_dly);
   assign wready  = wvalid && (w_cnt >= w_dly);
   assign arready = arvalid && (ar_cnt >= ar_dly);
   assign rvalid  = r_pend && (r_cnt >= r_dly);
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;
   assign wr_idx  = have_aw ? aw_addr_s[3:2] : awaddr[3:2];
   assign wr_data = have_w ? w_data_s : wdata;
   assign wr_strb = have_w ? w_strb_s : wstrb;
   assign rdata   = rdata_s;
   assign rresp   = rresp_cfg;
   assign bresp   = bresp_cfg;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_cnt  <= 0;
         w_cnt   <= 0;
         ar_cnt  <= 0;
         r_cnt   <= 0;
         have_aw <= 1'b0;
         have_w  <= 1'b0;
         r_pend  <= 1'b0;
         bvalid  <= 1'b0;
         rdata_s <= '0;
      end else begin
         aw_cnt <= (awvalid && !aw_hs) ? aw_cnt + 1 : 0;
         w_cnt  <= (wvalid && !w_hs) ? w_cnt + 1 : 0;
         ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
         if (aw_hs) begin
            have_aw   <= 1'b1;
            aw_addr_s <= awaddr;
         end
         if (w_hs) begin
            have_w   <= 1'b1;
            w_data_s <= wdata;
            w_strb_s <= wstrb;
         end
         if ((have_aw || aw_hs) && (have_w || w_hs) && !bvalid) begin
            for (int b = 0; b < 4; b++)
               if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            bvalid  <= 1'b1;
            have_aw <= 1'b0;
            have_w  <= 1'b0;
         end
         if (bvalid && bready) begin
            bvalid <= 1'b0;
            b_cnt  <= b_cnt + 1;
         end
         if (arvalid && arready) begin
            rdata_s <= mem[araddr[3:2]];
            r_pend  <= 1'b1;
            r_cnt   <= 0;
         end else if (rvalid && rready) begin
            r_pend <= 1'b0;
         end else if (r_pend) begin
            r_cnt <= r_cnt + 1;
         end
      end
   end

   // scoreboard monitor: compare every response handshake against the oldest expectation
   initial begin
      logic [34:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid && rsp_ready) begin
            rsp_cnt++;
            if (sb.size() == 0) begin
               chk("unexpected response", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_write", rsp_write, e[34]);
               chk("rsp_resp", rsp_resp, e[33:32]);
               chk("rsp_rdata", rsp_rdata, e[31:0]);
            end
         end
      end
   end

   // protocol monitor: valids held until handshake with stable payload, dropped after it
   initial begin
      logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0, p_rv = 0, p_rr = 0;
      logic [7:0]  p_awa = '0, p_ara = '0;
      logic [31:0] p_wd = '0, p_rd = '0;
      logic [3:0]  p_ws = '0;
      logic [1:0]  p_rs = '0;
      logic        p_rw = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            p_awv = 0; p_wv = 0; p_arv = 0; p_rv = 0;
         end else begin
            if (p_awv && !p_awr) begin
               chk("awvalid held", awvalid, 1);
               chk("awaddr stable", awaddr, p_awa);
            end
            if (p_awv && p_awr) chk("awvalid dropped", awvalid, 0);
            if (p_wv && !p_wr) begin
               chk("wvalid held", wvalid, 1);
               chk("wdata stable", wdata, p_wd);
               chk("wstrb stable", wstrb, p_ws);
            end
            if (p_wv && p_wr) chk("wvalid dropped", wvalid, 0);
            if (p_arv && !p_arr) begin
               chk("arvalid held", arvalid, 1);
               chk("araddr stable", araddr, p_ara);
            end
            if (p_arv && p_arr) chk("arvalid dropped", arvalid, 0);
            if (p_rv && !p_rr) begin
               chk("rsp_valid held", rsp_valid, 1);
               chk("rsp_rdata stable", rsp_rdata, p_rd);
               chk("rsp_resp stable", rsp_resp, p_rs);
               chk("rsp_write stable", rsp_write, p_rw);
               chk("cmd_ready low while responding", cmd_ready, 0);
            end
            p_awv = awvalid; p_awr = awready; p_awa = awaddr;
            p_wv = wvalid; p_wr = wready; p_wd = wdata; p_ws = wstrb;
            p_arv = arvalid; p_arr = arready; p_ara = araddr;
            p_rv = rsp_valid; p_rr = rsp_ready; p_rd = rsp_rdata; p_rs = rsp_resp; p_rw = rsp_write;
         end
      end
   end

   task automatic run_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [1:0] eresp, input logic [31:0] erd,
                          input int hold, input int exp_lat, input bit push);
      bit acc;
      int lat;
      if (push) sb.push_back({wr, eresp, erd});
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wd;
      cmd_wstrb = ws;
      acc = 0;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         if (cmd_ready) acc = 1;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      chk("cmd accepted", acc, 1);
      if (!push) return;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 200);
      chk("rsp_valid arrives", rsp_valid, 1);
      if (exp_lat > 0) chk("response latency", lat, exp_lat);
      for (int i = 0; i < hold; i++) begin
         chk("cmd_ready low during hold", cmd_ready, 0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("cmd_ready after rsp", cmd_ready, 1);
      chk("rsp_valid after rsp", rsp_valid, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset cmd_ready", cmd_ready, 1);
      chk("reset awvalid", awvalid, 0);
      chk("reset wvalid", wvalid, 0);
      chk("reset arvalid", arvalid, 0);
      chk("reset bready", bready, 0);
      chk("reset rready", rready, 0);
      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset rsp_rdata", rsp_rdata, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // zero-wait write: AW+W in one edge, rsp_valid after the third edge
      run_cmd(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 0, 3, 1);
      chk("slave reg1", mem[1], 32'hDEADBEEF);

      // W accepted three cycles before AW
      aw_dly = 3;
      run_cmd(1'b1, 8'h08, 32'h12345678, 4'hF, 2'b00, 32'h0, 0, 0, 1);
      chk("slave reg2", mem[2], 32'h12345678);
      aw_dly = 0;

      // read with arready delayed 2 and rvalid 1 cycle later
      ar_dly = 2; r_dly = 1;
      run_cmd(1'b0, 8'h04, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF, 0, 0, 1);
      ar_dly = 0; r_dly = 0;

      // partial-strobe write, bresp passed through; rsp_rdata must return to 0
      bresp_cfg = 2'b01;
      run_cmd(1'b1, 8'h08, 32'hAABBCCDD, 4'h5, 2'b01, 32'h0, 0, 0, 1);
      bresp_cfg = 2'b00;
      chk("slave reg2 strobed", mem[2], 32'h12BB56DD);

      // SLVERR on read, response held for 5 cycles
      rresp_cfg = 2'b10;
      run_cmd(1'b0, 8'h08, 32'h0, 4'h0, 2'b10, 32'h12BB56DD, 5, 0, 1);
      rresp_cfg = 2'b00;

      // zero-wait read
      run_cmd(1'b0, 8'h04, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF, 0, 3, 1);

      // reset in the middle of WR_ADDR_DATA with a stalled slave
      aw_dly = 10; w_dly = 10;
      run_cmd(1'b1, 8'h0C, 32'h55555555, 4'hF, 2'b00, 32'h0, 0, 0, 0);
      @(negedge clk);
      chk("awvalid before reset", awvalid, 1);
      chk("wvalid before reset", wvalid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("awvalid drops on reset", awvalid, 0);
      chk("wvalid drops on reset", wvalid, 0);
      chk("cmd_ready on reset", cmd_ready, 1);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      aw_dly = 0; w_dly = 0;
      @(negedge clk);
      chk("cmd_ready after reset", cmd_ready, 1);
      chk("awvalid after reset", awvalid, 0);

      // traffic still works after reset
      run_cmd(1'b1, 8'h0C, 32'h0BADF00D, 4'hF, 2'b00, 32'h0, 0, 3, 1);
      run_cmd(1'b0, 8'h0C, 32'h0, 4'h0, 2'b00, 32'h0BADF00D, 0, 3, 1);

      repeat (5) @(negedge clk);
      chk("scoreboard drained", sb.size(), 0);
      chk("response count", rsp_cnt, 8);
      chk("B handshake count", b_cnt, 4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
